// File: rtl/frame_stream_ctrl.sv
// Frame streaming controller: source RAM -> core (valid/ready), core results -> destination RAM.
// Ports: clk_i/rst_i/start_i, src_* read port, core_* pixel stream, res_* result stream, dst_* write port, busy/done/err.
module frame_stream_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 17,
    parameter int IN_COUNT  = 76800,
    parameter int OUT_COUNT = 76800,
    parameter int RD_LAT    = 1,
    parameter int FIFO_D    = RD_LAT + 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          src_en_o,
    output logic [AW-1:0] src_addr_o,
    input  logic [DW-1:0] src_data_i,
    output logic          core_valid_o,
    output logic [DW-1:0] core_data_o,
    input  logic          core_ready_i,
    input  logic          res_valid_i,
    input  logic [DW-1:0] res_data_i,
    output logic          res_ready_o,
    output logic          dst_en_o,
    output logic          dst_we_o,
    output logic [AW-1:0] dst_addr_o,
    output logic [DW-1:0] dst_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D + 1) + 1;
    localparam logic [AW:0]   IN_CNT  = (AW+1)'(IN_COUNT);
    localparam logic [AW:0]   OUT_CNT = (AW+1)'(OUT_COUNT);
    localparam logic [CW-1:0] DEPTH   = CW'(FIFO_D);
    localparam logic [PW-1:0] LAST    = PW'(FIFO_D - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AW:0]       r_rd_cnt;
    logic [AW:0]       r_sent_cnt;
    logic [AW:0]       r_wr_cnt;
    logic [RD_LAT-1:0] r_pipe;
    logic [DW-1:0]     r_mem [FIFO_D];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_err;

    logic [CW-1:0] w_inflight;
    logic          w_run;
    logic          w_start;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_res_acc;
    logic          w_res_bad;

    // Reads still travelling through the RAM reserve a FIFO slot.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_pipe[i]);
        end
    end

    assign w_run     = (r_state == S_RUN);
    assign w_start   = start_i && !w_run;
    assign w_issue   = w_run && (r_rd_cnt < IN_CNT)
                     && ((r_count + w_inflight) < DEPTH);
    assign w_push    = r_pipe[RD_LAT-1];
    assign w_pop     = core_valid_o && core_ready_i;
    assign w_res_acc = res_valid_i && res_ready_o;
    assign w_res_bad = res_valid_i && !res_ready_o;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN:   if ((r_sent_cnt == IN_CNT) && (r_wr_cnt == OUT_CNT))
                         w_state_nxt = S_DONE;
            S_DONE:  if (start_i) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_rd_cnt   <= '0;
            r_sent_cnt <= '0;
            r_wr_cnt   <= '0;
            r_pipe     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_rd_cnt   <= '0;
                r_sent_cnt <= '0;
                r_wr_cnt   <= '0;
                r_pipe     <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
                r_err      <= 1'b0;
            end else begin
                if (w_issue) r_rd_cnt <= r_rd_cnt + 1'b1;
                r_pipe[0] <= w_issue;
                for (int i = 1; i < RD_LAT; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
                if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
                if (w_pop) begin
                    r_rptr     <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
                    r_sent_cnt <= r_sent_cnt + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_res_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_res_bad) r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= src_data_i;
    end

    assign src_en_o     = w_issue;
    assign src_addr_o   = w_issue ? r_rd_cnt[AW-1:0] : '0;
    assign core_valid_o = (r_count != '0);
    assign core_data_o  = core_valid_o ? r_mem[r_rptr] : '0;
    assign res_ready_o  = w_run && (r_wr_cnt < OUT_CNT);
    assign dst_en_o     = w_res_acc;
    assign dst_we_o     = w_res_acc;
    assign dst_addr_o   = w_res_acc ? r_wr_cnt[AW-1:0] : '0;
    assign dst_data_o   = w_res_acc ? res_data_i : '0;
    assign busy_o       = w_run;
    assign done_o       = (r_state == S_DONE);
    assign err_o        = r_err;

    // Slots are reserved at issue time, so a push into a full FIFO is a design bug.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && (r_count == DEPTH)));

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Directed bench for frame_stream_ctrl: two instances (RD_LAT=1 16/16, RD_LAT=3 16/4)
// with RAM and core models around each.
module tb_frame_stream_ctrl;
    localparam int DW = 8;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int checks = 0;
    int failures = 0;

    logic          start0, s0_en, c0_valid, c0_ready, r0_valid, r0_ready;
    logic          d0_en, d0_we, busy0, done0, err0;
    logic [AW-1:0] s0_addr, d0_addr;
    logic [DW-1:0] s0_data, c0_data, r0_data, d0_data;

    logic          start1, s1_en, c1_valid, c1_ready, r1_valid, r1_ready;
    logic          d1_en, d1_we, busy1, done1, err1;
    logic [AW-1:0] s1_addr, d1_addr;
    logic [DW-1:0] s1_data, c1_data, r1_data, d1_data;

    frame_stream_ctrl #(.DW(DW), .AW(AW), .IN_COUNT(16), .OUT_COUNT(16), .RD_LAT(1)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0),
        .src_en_o(s0_en), .src_addr_o(s0_addr), .src_data_i(s0_data),
        .core_valid_o(c0_valid), .core_data_o(c0_data), .core_ready_i(c0_ready),
        .res_valid_i(r0_valid), .res_data_i(r0_data), .res_ready_o(r0_ready),
        .dst_en_o(d0_en), .dst_we_o(d0_we), .dst_addr_o(d0_addr), .dst_data_o(d0_data),
        .busy_o(busy0), .done_o(done0), .err_o(err0));

    frame_stream_ctrl #(.DW(DW), .AW(AW), .IN_COUNT(16), .OUT_COUNT(4), .RD_LAT(3)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
        .src_en_o(s1_en), .src_addr_o(s1_addr), .src_data_i(s1_data),
        .core_valid_o(c1_valid), .core_data_o(c1_data), .core_ready_i(c1_ready),
        .res_valid_i(r1_valid), .res_data_i(r1_data), .res_ready_o(r1_ready),
        .dst_en_o(d1_en), .dst_we_o(d1_we), .dst_addr_o(d1_addr), .dst_data_o(d1_data),
        .busy_o(busy1), .done_o(done1), .err_o(err1));

    // Source RAMs: latency 1 and 3
    logic [DW-1:0] src0 [16];
    logic [DW-1:0] src1 [16];
    logic [DW-1:0] p1, p2, p3;
    always @(posedge clk) s0_data <= s0_en ? src0[s0_addr[3:0]] : '0;
    always @(posedge clk) begin
        p1 <= s1_en ? src1[s1_addr[3:0]] : '0;
        p2 <= p1;
        p3 <= p2;
    end
    assign s1_data = p3;

    // Core 0: echo each accepted pixel 3 cycles later
    logic          e1v, e2v, e3v, man0, man0_v;
    logic [DW-1:0] e1d, e2d, e3d, man0_d;
    always @(posedge clk) begin
        if (rst) begin
            e1v <= 1'b0; e2v <= 1'b0; e3v <= 1'b0;
        end else begin
            e1v <= c0_valid && c0_ready; e1d <= c0_data;
            e2v <= e1v; e2d <= e1d;
            e3v <= e2v; e3d <= e2d;
        end
    end
    assign r0_valid = man0 ? man0_v : e3v;
    assign r0_data  = man0 ? man0_d : e3d;

    // Core 1: one result (pixel ^ A5) for the first of every 4 pixels
    logic [1:0]    q1;
    logic          pv1, man1, man1_v;
    logic [DW-1:0] pd1, man1_d;
    always @(posedge clk) begin
        if (rst) begin
            q1 <= '0; pv1 <= 1'b0;
        end else begin
            if (pv1 && r1_ready && !man1) pv1 <= 1'b0;
            if (c1_valid && c1_ready) begin
                q1 <= q1 + 1'b1;
                if (q1 == 2'd0) begin
                    pv1 <= 1'b1;
                    pd1 <= c1_data ^ 8'hA5;
                end
            end
        end
    end
    assign r1_valid = man1 ? man1_v : pv1;
    assign r1_data  = man1 ? man1_d : pd1;

    // Destination write logs
    int            w0_n = 0, w1_n = 0;
    logic [AW-1:0] w0_a [128], w1_a [128];
    logic [DW-1:0] w0_d [128], w1_d [128];
    always @(posedge clk) if (d0_en && d0_we) begin
        if (w0_n < 128) begin w0_a[w0_n] <= d0_addr; w0_d[w0_n] <= d0_data; end
        w0_n <= w0_n + 1;
    end
    always @(posedge clk) if (d1_en && d1_we) begin
        if (w1_n < 128) begin w1_a[w1_n] <= d1_addr; w1_d[w1_n] <= d1_data; end
        w1_n <= w1_n + 1;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s0_en, s0_addr, c0_valid, c0_data, r0_ready, d0_en, d0_we, d0_addr,
             d0_data, busy0, done0, err0} !== 34'd0) begin
            failures++;
            $display("FAIL reset_u0: outputs=%h expected 0", {s0_en, s0_addr, c0_valid,
                     c0_data, r0_ready, d0_en, d0_we, d0_addr, d0_data, busy0, done0, err0});
        end
        checks++;
        if ({s1_en, s1_addr, c1_valid, c1_data, r1_ready, d1_en, d1_we, d1_addr,
             d1_data, busy1, done1, err1} !== 34'd0) begin
            failures++;
            $display("FAIL reset_u1: outputs=%h expected 0", {s1_en, s1_addr, c1_valid,
                     c1_data, r1_ready, d1_en, d1_we, d1_addr, d1_data, busy1, done1, err1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_err();
        int base;
        base = w0_n;
        man0 = 1'b1; man0_v = 1'b1; man0_d = 8'h5A;
        #1;
        checks++;
        if (r0_ready !== 1'b0 || d0_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_res: ready=%b dst_en=%b expected 0/0", r0_ready, d0_en);
        end
        @(negedge clk);
        man0 = 1'b0;
        checks++;
        if (err0 !== 1'b1) begin
            failures++;
            $display("FAIL idle_err: err=%b expected 1", err0);
        end
        @(negedge clk);
        checks++;
        if (err0 !== 1'b1 || w0_n != base) begin
            failures++;
            $display("FAIL idle_sticky: err=%b writes=%0d expected 1/0", err0, w0_n - base);
        end
    endtask

    task automatic frame0(input string nm);
        int base, dk;
        base = w0_n;
        dk = -1;
        start0 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start0 = 1'b0;
                checks++;
                if (s0_en !== 1'b1 || s0_addr !== '0) begin
                    failures++;
                    $display("FAIL %s first_rd: en=%b addr=%0d expected 1/0", nm, s0_en, s0_addr);
                end
                checks++;
                if ({busy0, done0, err0} !== 3'b100) begin
                    failures++;
                    $display("FAIL %s start_flags: bde=%b expected 100", nm, {busy0, done0, err0});
                end
            end
            if (k == 2) begin
                checks++;
                if (c0_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s early_valid: valid=%b expected 0", nm, c0_valid);
                end
            end
            if (k >= 3 && k <= 18) begin
                checks++;
                if (c0_valid !== 1'b1 || c0_data !== src0[k-3]) begin
                    failures++;
                    $display("FAIL %s pix%0d: valid=%b data=%h expected 1/%h",
                             nm, k - 3, c0_valid, c0_data, src0[k-3]);
                end
            end
            if (done0 === 1'b1 && dk < 0) dk = k;
        end
        checks++;
        if (dk != 23) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected 23", nm, dk);
        end
        checks++;
        if (w0_n - base != 16 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL %s writes: n=%0d busy=%b expected 16/0", nm, w0_n - base, busy0);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w0_a[base+i] !== AW'(i) || w0_d[base+i] !== src0[i]) begin
                failures++;
                $display("FAIL %s dst%0d: addr=%0d data=%h expected %0d/%h",
                         nm, i, w0_a[base+i], w0_d[base+i], i, src0[i]);
            end
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 16; i++) src0[i] = 8'h20 + 8'(i);
        frame0("ramp");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) src0[i] = 8'(i * 13 + 7);
        frame0("b2b");
    endtask

    task automatic test_reset_mid();
        int base;
        for (int i = 0; i < 16; i++) src0[i] = 8'hC0 ^ 8'(i * 5);
        start0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        checks++;
        if (c0_valid !== 1'b1 || c0_data !== src0[7]) begin
            failures++;
            $display("FAIL rstmid_pix7: valid=%b data=%h expected 1/%h", c0_valid, c0_data, src0[7]);
        end
        rst = 1'b1;
        @(negedge clk);
        base = w0_n;
        checks++;
        if ({s0_en, s0_addr, c0_valid, c0_data, r0_ready, d0_en, d0_we, d0_addr,
             d0_data, busy0, done0, err0} !== 34'd0) begin
            failures++;
            $display("FAIL rstmid_outs: outputs=%h expected 0", {s0_en, s0_addr, c0_valid,
                     c0_data, r0_ready, d0_en, d0_we, d0_addr, d0_data, busy0, done0, err0});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (w0_n != base || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet: writes=%0d busy=%b expected 0/0", w0_n - base, busy0);
        end
        frame0("rstmid");
    endtask

    task automatic test_backpressure();
        int base, issued, sent, outst;
        bit sawfull, donechk, pv, pr, exp_en;
        logic [DW-1:0] pd;
        base = w1_n;
        issued = 0; sent = 0; sawfull = 0; donechk = 0; pv = 0; pr = 0; pd = '0;
        for (int i = 0; i < 16; i++) src1[i] = 8'h40 + 8'(i * 3);
        c1_ready = 1'b0;
        start1 = 1'b1;
        for (int k = 1; k <= 300 && !donechk; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            outst = issued - sent;
            if (busy1 === 1'b1) begin
                exp_en = (issued < 16) && (outst < 5);
                checks++;
                if (outst > 5 || s1_en !== exp_en) begin
                    failures++;
                    $display("FAIL bp_issue k%0d: en=%b outstanding=%0d expected en=%b max 5",
                             k, s1_en, outst, exp_en);
                end
                if (s1_en === 1'b1) begin
                    checks++;
                    if (s1_addr !== AW'(issued)) begin
                        failures++;
                        $display("FAIL bp_addr: got %0d expected %0d", s1_addr, issued);
                    end
                end
            end
            if (pv && !pr) begin
                checks++;
                if (c1_valid !== 1'b1 || c1_data !== pd) begin
                    failures++;
                    $display("FAIL bp_stable: valid=%b data=%h expected 1/%h", c1_valid, c1_data, pd);
                end
            end
            if (outst == 5) sawfull = 1;
            if (done1 === 1'b1) begin
                donechk = 1;
                checks++;
                if (sent != 16 || w1_n - base != 4) begin
                    failures++;
                    $display("FAIL bp_done: sent=%0d writes=%0d expected 16/4", sent, w1_n - base);
                end
            end
            if (s1_en === 1'b1) issued++;
            c1_ready = (k < 12) ? 1'b0 : 1'($urandom % 2);
            pv = c1_valid; pr = c1_ready; pd = c1_data;
            if (c1_valid === 1'b1 && c1_ready) begin
                checks++;
                if (sent >= 16 || c1_data !== src1[sent[3:0]]) begin
                    failures++;
                    $display("FAIL bp_pix%0d: data=%h expected %h", sent, c1_data, src1[sent[3:0]]);
                end
                sent++;
            end
        end
        checks++;
        if (!donechk || !sawfull || issued != 16 || sent != 16) begin
            failures++;
            $display("FAIL bp_totals: done=%b full=%b issued=%0d sent=%0d expected 1/1/16/16",
                     donechk, sawfull, issued, sent);
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (w1_a[base+g] !== AW'(g) || w1_d[base+g] !== (src1[4*g] ^ 8'hA5)) begin
                failures++;
                $display("FAIL bp_dst%0d: addr=%0d data=%h expected %0d/%h",
                         g, w1_a[base+g], w1_d[base+g], g, src1[4*g] ^ 8'hA5);
            end
        end
    endtask

    task automatic test_out_count_extra();
        int base;
        bit got;
        for (int i = 0; i < 16; i++) src1[i] = 8'(i * 29 + 1);
        base = w1_n;
        got = 0;
        c1_ready = 1'b1;
        start1 = 1'b1;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start1 = 1'b0;
                checks++;
                if ({busy1, done1} !== 2'b10) begin
                    failures++;
                    $display("FAIL oc_start: busy/done=%b expected 10", {busy1, done1});
                end
            end
            if (w1_n - base == 4) got = 1;
        end
        c1_ready = 1'b0;
        man1 = 1'b1; man1_v = 1'b1; man1_d = 8'h77;
        #1;
        checks++;
        if (!got || busy1 !== 1'b1 || r1_ready !== 1'b0 || d1_en !== 1'b0) begin
            failures++;
            $display("FAIL oc_extra: got4=%b busy=%b ready=%b dst_en=%b expected 1/1/0/0",
                     got, busy1, r1_ready, d1_en);
        end
        @(negedge clk);
        man1 = 1'b0;
        c1_ready = 1'b1;
        checks++;
        if (err1 !== 1'b1 || w1_n - base != 4) begin
            failures++;
            $display("FAIL oc_err: err=%b writes=%0d expected 1/4", err1, w1_n - base);
        end
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) got = 1;
        end
        checks++;
        if (!got || err1 !== 1'b1) begin
            failures++;
            $display("FAIL oc_done: done=%b err=%b expected 1/1", got, err1);
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (w1_a[base+g] !== AW'(g) || w1_d[base+g] !== (src1[4*g] ^ 8'hA5)) begin
                failures++;
                $display("FAIL oc_dst%0d: addr=%0d data=%h expected %0d/%h",
                         g, w1_a[base+g], w1_d[base+g], g, src1[4*g] ^ 8'hA5);
            end
        end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if ({busy1, done1, err1} !== 3'b100) begin
            failures++;
            $display("FAIL oc_restart: bde=%b expected 100", {busy1, done1, err1});
        end
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL oc_redone: done never seen");
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        c0_ready = 1'b1; c1_ready = 1'b0;
        man0 = 1'b0; man0_v = 1'b0; man0_d = '0;
        man1 = 1'b0; man1_v = 1'b0; man1_d = '0;
        for (int i = 0; i < 16; i++) begin
            src0[i] = '0;
            src1[i] = '0;
        end
        test_reset();
        test_idle_err();
        test_ramp();
        test_back_to_back();
        test_reset_mid();
        test_backpressure();
        test_out_count_extra();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_stream_ctrl.md
# frame_stream_ctrl

Parametrised frame streaming controller for the image-processing datapath. It reads a full frame from a source RAM and streams it into a processing core over a valid/ready handshake. At the same time it accepts the core's results and writes them to a destination RAM, then flags completion. Read latency, pixel width, and input/output frame lengths are parameters. Fixed wait-state counting is replaced by handshakes, and feeding and collection run concurrently instead of in sequence.

## Interface
- DW, 8: pixel/data width.
- AW, 17: RAM address width; 2^AW >= max(IN_COUNT, OUT_COUNT).
- IN_COUNT, 76800: pixels read from the source RAM and sent to the core; must be >= 1.
- OUT_COUNT, 76800: results expected from the core and written to the destination RAM; must be >= 1.
- RD_LAT, 1: source RAM read latency in cycles (1..4).
- FIFO_D, RD_LAT+2: internal prefetch FIFO depth.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle start pulse; ignored unless in IDLE or DONE.
- src_en_o  out  1  source RAM read enable.
- src_addr_o  out  AW  source read address.
- src_data_i  in  DW  source read data, valid RD_LAT cycles after src_en_o.
- core_valid_o  out  1  pixel available to the core.
- core_data_o  out  DW  pixel to the core.
- core_ready_i  in  1  core accepts a pixel.
- res_valid_i  in  1  core result available.
- res_data_i  in  DW  core result.
- res_ready_o  out  1  controller accepts a result.
- dst_en_o  out  1  destination RAM enable.
- dst_we_o  out  1  destination RAM write enable.
- dst_addr_o  out  AW  destination write address.
- dst_data_o  out  DW  destination write data.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE; cleared by start_i or reset.
- err_o  out  1  sticky: result offered outside RUN; cleared by start_i or reset.

## Operation
- States: IDLE -> RUN on start_i. RUN -> DONE when sent_cnt == IN_COUNT and wr_cnt == OUT_COUNT. DONE -> RUN on start_i.
- On start, rd_cnt, inflight, FIFO, sent_cnt, wr_cnt and err_o are cleared.
- Read issue condition: RUN, rd_cnt < IN_COUNT, and fifo_count + inflight < FIFO_D.
  - On issue: src_en_o = 1, src_addr_o = rd_cnt, rd_cnt increments.
- Each issued read pushes src_data_i into the FIFO exactly RD_LAT cycles later. The FIFO can never overflow; an overflow is a design error, guarded by an assertion.
- core_valid_o = FIFO non-empty; core_data_o = FIFO head.
  - A transfer occurs when core_valid_o && core_ready_i; the FIFO pops and sent_cnt increments.
  - Data and valid stay stable while ready is low.
- res_ready_o = RUN && wr_cnt < OUT_COUNT.
  - On res_valid_i && res_ready_o, in the same cycle: dst_en_o = dst_we_o = 1, dst_addr_o = wr_cnt, dst_data_o = res_data_i; wr_cnt increments.
  - These outputs are combinational from the handshake.
- Feeding and collection run independently. Results may arrive before all pixels are sent.
- res_valid_i high while in IDLE or DONE, or while in RUN with wr_cnt == OUT_COUNT, sets err_o. Such data is never written.
- Counters are AW+1 bits wide so the equality compare at IN_COUNT or OUT_COUNT = 2^AW does not wrap.

## Timing
- Reset values: state IDLE; all outputs 0; counters 0; FIFO empty.
- Reset mid-frame aborts immediately. Reads still in flight are discarded and nothing more is written.
- Start latency: start_i sampled at edge E0.
  - First src_en_o in cycle E0+1.
  - First core_valid_o in cycle E0+2+RD_LAT (E0+3 for RD_LAT=1).
- Throughput: 1 pixel/clock with core_ready_i held high, for any RD_LAT.
- Backpressure: with ready low, at most FIFO_D pixels are buffered and issuing stalls. Issuing resumes in the cycle after the pop that frees a slot.
- A DW-bit result is written in the cycle it is accepted; no write buffering.
- done_o rises the cycle after the final counter condition is met; busy_o falls in the same cycle.
- start_i in the same cycle as the last transfer (state RUN) is ignored.

## Test plan
- Ramp frame, IN_COUNT = OUT_COUNT = 16, RD_LAT = 1, core echoes input with 3-cycle delay, ready always high -> dst[i] = src[i] for i = 0..15; first core_valid_o at E0+3; done_o at a fixed, checked cycle; no bubbles after the first pixel.
- Random core_ready_i (50%) with RD_LAT = 3 -> no pixel lost or duplicated; FIFO occupancy never exceeds 5; src_en_o stalls while FIFO_D is full.
- IN_COUNT = 16, OUT_COUNT = 4, core emitting one result per 4 inputs -> 4 writes to addresses 0..3; done_o only after both 16 pixels sent and 4 results written.
- Extra result after OUT_COUNT reached, and res_valid_i asserted in IDLE -> res_ready_o = 0, no dst write, err_o = 1; next start_i clears err_o.
- rst_i asserted mid-frame at pixel 7 -> all outputs 0 next cycle; a subsequent start_i runs a full correct frame from address 0.
- Two back-to-back frames via start_i in DONE -> second frame is correct; done_o drops the cycle after start.
